// File: rtl/keypad_emulator.sv
// Purpose : emulates a 4x4 key switch matrix driven by a row/column scanner, replaying queued key codes.
// Latency : a queued key closes one clock after it reaches an idle head; y follows x with zero-cycle delay.
// Backpressure: key_ready drops while the 4-entry key queue is full; offers without key_ready are dropped.
//
// Ports:
//   clk, rst            single clock, synchronous active-high reset
//   key_code/valid/ready key queue input handshake; key_code[3:2] = column, [1:0] = row
//   x                   column drive from the scanner (active-high)
//   y                   row sense back to the scanner (active-high, combinational from x)
//   pressed             registered, high exactly while a key is held closed
//   busy                registered, high while a key is in progress or keys are queued
module keypad_emulator #(
   parameter int unsigned PRESS_CYCLES = 1000,
   parameter int unsigned GAP_CYCLES   = 1000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] key_code,
   input  logic       key_valid,
   output logic       key_ready,
   input  logic [3:0] x,
   output logic [3:0] y,
   output logic       pressed,
   output logic       busy
);

   // Counters are loaded with N-1 so that the phase covers counts N-1..0, i.e. exactly N clocks.
   localparam logic [15:0] PRESS_LOAD = 16'(PRESS_CYCLES - 1);
   localparam logic [15:0] GAP_LOAD   = 16'(GAP_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PRESS = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [3:0]  cur_code_q, cur_code_d;
   logic        pressed_q, pressed_d;
   logic        busy_q, busy_d;

   logic [3:0]  fifo_q [4];
   logic [1:0]  wr_ptr_q, wr_ptr_d;
   logic [1:0]  rd_ptr_q, rd_ptr_d;
   logic [2:0]  count_q, count_d;
   logic        push;
   logic        pop;

   // ------------------------------------------------------------------
   // Key queue
   // ------------------------------------------------------------------
   assign key_ready = (count_q != 3'd4);
   assign push      = key_valid && key_ready;
   // The head is consumed only when the emulator is idle; push and pop may coincide.
   assign pop       = (state_q == ST_IDLE) && (count_q != 3'd0);

   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + 2'd1 : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + 2'd1 : rd_ptr_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 3'd1;
         2'b01:   count_d = count_q - 3'd1;
         default: count_d = count_q;
      endcase
   end

   // Storage needs no reset: the pointers and occupancy define which slots are live,
   // so a write that lands while rst is high is never read.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_q[wr_ptr_q] <= key_code;
      end
   end

   // ------------------------------------------------------------------
   // Press/gap sequencer: next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      cur_code_d = cur_code_q;
      case (state_q)
         ST_IDLE: begin
            if (pop) begin
               cur_code_d = fifo_q[rd_ptr_q];
               cnt_d      = PRESS_LOAD;
               state_d    = ST_PRESS;
            end
         end
         ST_PRESS: begin
            if (cnt_q == 16'd0) begin
               cnt_d   = GAP_LOAD;
               state_d = ST_GAP;
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         ST_GAP: begin
            if (cnt_q == 16'd0) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   always_comb begin
      // Status flags are registered from the post-edge state so they line up with state_q.
      pressed_d = (state_d == ST_PRESS);
      busy_d    = (state_d != ST_IDLE) || (count_d != 3'd0);

      // Switch path: only the column of the held key matters, so stray x bits have no effect.
      y = 4'b0000;
      if (pressed_q && x[cur_code_q[3:2]]) begin
         y[cur_code_q[1:0]] = 1'b1;
      end
   end

   assign pressed = pressed_q;
   assign busy    = busy_q;

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= 16'd0;
         cur_code_q <= 4'd0;
         pressed_q  <= 1'b0;
         busy_q     <= 1'b0;
         wr_ptr_q   <= 2'd0;
         rd_ptr_q   <= 2'd0;
         count_q    <= 3'd0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         cur_code_q <= cur_code_d;
         pressed_q  <= pressed_d;
         busy_q     <= busy_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
      end
   end

endmodule

// File: tb/tb_keypad_emulator.sv
// Bench for keypad_emulator: scenario tasks plus randomized traffic, checked against a
// timeline model (key start cycle + queue) that derives every output from press/gap durations.
module tb_keypad_emulator;

   localparam longint MP = 4;
   localparam longint MG = 3;

   logic       clk;
   logic       rst;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_ready;
   logic [3:0] x;
   logic [3:0] y;
   logic       pressed;
   logic       busy;

   logic       f_rst;
   logic [3:0] f_code;
   logic       f_valid;
   logic       f_ready;
   logic [3:0] f_x;
   logic [3:0] f_y;
   logic       f_pressed;
   logic       f_busy;

   logic [6:0] obs;
   assign obs = {pressed, busy, key_ready, y};

   int n_checks = 0;
   int n_pass   = 0;

   keypad_emulator #(.PRESS_CYCLES(4), .GAP_CYCLES(3)) u_dut (
      .clk(clk), .rst(rst), .key_code(key_code), .key_valid(key_valid), .key_ready(key_ready),
      .x(x), .y(y), .pressed(pressed), .busy(busy)
   );

   keypad_emulator #(.PRESS_CYCLES(1), .GAP_CYCLES(1)) u_fast (
      .clk(clk), .rst(f_rst), .key_code(f_code), .key_valid(f_valid), .key_ready(f_ready),
      .x(f_x), .y(f_y), .pressed(f_pressed), .busy(f_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ------------------------------------------------------------------
   // Reference model: a key popped at edge s is closed during cycles
   // [s, s+MP), released during [s+MP, s+MP+MG), idle afterwards.
   // ------------------------------------------------------------------
   int         mq[$];
   longint     m_s = -1000;
   longint     m_e = 0;
   logic [3:0] m_cur = 4'd0;

   function automatic int m_phase();
      if (m_e >= m_s && m_e < m_s + MP) return 1;
      if (m_e >= m_s + MP && m_e < m_s + MP + MG) return 2;
      return 0;
   endfunction

   function automatic logic [6:0] m_expect(input logic [3:0] xv);
      logic       pr;
      logic       bz;
      logic       rd;
      logic [3:0] yv;
      pr = (m_phase() == 1);
      bz = (m_phase() != 0) || (mq.size() != 0);
      rd = (mq.size() < 4);
      yv = 4'b0000;
      if (pr && xv[m_cur[3:2]]) yv[m_cur[1:0]] = 1'b1;
      return {pr, bz, rd, yv};
   endfunction

   task automatic tick();
      int sz;
      if (rst) begin
         mq.delete();
         m_s   = -1000;
         m_cur = 4'd0;
      end else begin
         sz = mq.size();
         if (m_phase() == 0 && sz > 0) begin
            m_cur = 4'(mq.pop_front());
            m_s   = m_e + 1;
         end
         if (key_valid && sz < 4) mq.push_back(int'(key_code));
      end
      m_e++;
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      key_valid = 1'b0;
      for (int i = 0; i < 100 && (m_phase() != 0 || mq.size() != 0); i++) tick();
   endtask

   // ------------------------------------------------------------------
   task automatic test_reset();
      rst = 1'b1; f_rst = 1'b1;
      key_valid = 1'b1; key_code = 4'h5; x = 4'b1111;
      f_valid = 1'b0; f_code = 4'h0; f_x = 4'b1111;
      tick(); tick(); tick();
      #1;
      n_checks++;
      if (obs !== 7'b0010000) $display("FAIL reset_state: got %b exp %b", obs, 7'b0010000);
      else n_pass++;
      rst = 1'b0; f_rst = 1'b0; key_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         n_checks++;
         if (obs !== m_expect(x)) $display("FAIL reset_idle c%0d: got %b exp %b", i, obs, m_expect(x));
         else n_pass++;
         tick();
      end
   endtask

   task automatic test_single_key();
      int press_cnt;
      int stray_y;
      press_cnt = 0; stray_y = 0;
      key_code = 4'h6; key_valid = 1'b1; x = 4'b0001;
      #1;
      tick();
      key_valid = 1'b0;
      for (int i = 0; i < 14; i++) begin
         x = 4'(1 << (i % 4));
         #1;
         if (pressed) press_cnt++;
         if (y != 4'b0000 && !(x == 4'b0010 && y == 4'b0100)) stray_y++;
         n_checks++;
         if (obs !== m_expect(x)) $display("FAIL single c%0d: got %b exp %b", i, obs, m_expect(x));
         else n_pass++;
         tick();
      end
      n_checks++;
      if (press_cnt !== 4) $display("FAIL single_press_len: got %0d exp 4", press_cnt);
      else n_pass++;
      n_checks++;
      if (stray_y !== 0) $display("FAIL single_y_rows: got %0d bad cycles exp 0", stray_y);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [3:0] codes [4];
      codes[0] = 4'h1; codes[1] = 4'h5; codes[2] = 4'h9; codes[3] = 4'hD;
      for (int i = 0; i < 4; i++) begin
         key_code = codes[i]; key_valid = 1'b1; x = 4'(1 << (i % 4));
         #1;
         n_checks++;
         if (key_ready !== 1'b1) $display("FAIL b2b_ready k%0d: got %b exp 1", i, key_ready);
         else n_pass++;
         n_checks++;
         if (obs !== m_expect(x)) $display("FAIL b2b_push c%0d: got %b exp %b", i, obs, m_expect(x));
         else n_pass++;
         tick();
      end
      key_valid = 1'b0;
      for (int i = 0; i < 36; i++) begin
         x = 4'($urandom);
         #1;
         n_checks++;
         if (obs !== m_expect(x)) $display("FAIL b2b_replay c%0d: got %b exp %b", i, obs, m_expect(x));
         else n_pass++;
         tick();
      end
   endtask

   task automatic test_fifo_full();
      for (int i = 0; i < 14; i++) begin
         key_valid = 1'b1; key_code = 4'($urandom); x = 4'($urandom);
         #1;
         if (i == 5 || i == 11) begin
            n_checks++;
            if (key_ready !== 1'b0) $display("FAIL full_ready c%0d: got %b exp 0", i, key_ready);
            else n_pass++;
         end
         if (i == 10) begin
            n_checks++;
            if (key_ready !== 1'b1) $display("FAIL full_ready_after_pop: got %b exp 1", key_ready);
            else n_pass++;
         end
         n_checks++;
         if (obs !== m_expect(x)) $display("FAIL full c%0d: got %b exp %b", i, obs, m_expect(x));
         else n_pass++;
         tick();
      end
      drain();
   endtask

   task automatic test_multi_x();
      key_code = 4'hF; key_valid = 1'b1; x = 4'b0000;
      #1;
      tick();
      key_valid = 1'b0;
      tick();
      x = 4'b1111;
      #1;
      n_checks++;
      if (y !== 4'b1000) $display("FAIL x1111_y: got %b exp 1000", y);
      else n_pass++;
      x = 4'b0111;
      #1;
      n_checks++;
      if (y !== 4'b0000) $display("FAIL x0111_y: got %b exp 0000", y);
      else n_pass++;
      n_checks++;
      if (obs !== m_expect(x)) $display("FAIL multi_x: got %b exp %b", obs, m_expect(x));
      else n_pass++;
      drain();
   endtask

   task automatic test_reset_mid_press();
      key_valid = 1'b1; x = 4'b1111;
      key_code = 4'hA; #1; tick();
      key_code = 4'hB; #1; tick();
      key_code = 4'hC; #1; tick();
      key_valid = 1'b0;
      #1;
      n_checks++;
      if (y !== 4'b0100) $display("FAIL rst_mid_pre_y: got %b exp 0100", y);
      else n_pass++;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      n_checks++;
      if (obs !== 7'b0010000) $display("FAIL rst_mid_post: got %b exp 0010000", obs);
      else n_pass++;
      for (int i = 0; i < 20; i++) begin
         #1;
         n_checks++;
         if (pressed !== 1'b0 || obs !== m_expect(x))
            $display("FAIL rst_mid_noreplay c%0d: got %b exp %b", i, obs, m_expect(x));
         else n_pass++;
         tick();
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         rst       = ($urandom_range(0, 99) == 0);
         key_valid = ($urandom_range(0, 2) == 0);
         key_code  = 4'($urandom);
         x = ($urandom_range(0, 1) == 1) ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom);
         #1;
         n_checks++;
         if (obs !== m_expect(x)) $display("FAIL random c%0d: got %b exp %b", i, obs, m_expect(x));
         else n_pass++;
         tick();
      end
      rst = 1'b0;
      drain();
   endtask

   task automatic test_min_timing();
      logic [7:0] pat;
      pat = 8'b1001_0000;
      f_x = 4'b1111;
      f_code = 4'h3; f_valid = 1'b1;
      #1;
      tick();
      f_code = 4'h7;
      #1;
      n_checks++;
      if (f_pressed !== 1'b0) $display("FAIL fast_pre: got %b exp 0", f_pressed);
      else n_pass++;
      tick();
      f_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         #1;
         n_checks++;
         if (f_pressed !== pat[7 - i]) $display("FAIL fast_pressed c%0d: got %b exp %b", i, f_pressed, pat[7 - i]);
         else n_pass++;
         if (pat[7 - i]) begin
            n_checks++;
            if (f_y !== 4'b1000) $display("FAIL fast_y c%0d: got %b exp 1000", i, f_y);
            else n_pass++;
         end
         tick();
      end
   endtask

   initial begin
      rst = 1'b1; key_valid = 1'b0; key_code = 4'h0; x = 4'b0000;
      f_rst = 1'b1; f_valid = 1'b0; f_code = 4'h0; f_x = 4'b0000;
      test_reset();
      test_single_key();
      drain();
      test_back_to_back();
      drain();
      test_fifo_full();
      test_multi_x();
      test_reset_mid_press();
      test_random();
      test_min_timing();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/keypad_emulator.md
KEYPAD_EMULATOR -- requirements
Module: keypad_emulator

Interface
REQ-001 Parameter PRESS_CYCLES, default 1000: clocks a key is held closed; legal range 1..65535.
REQ-002 Parameter GAP_CYCLES, default 1000: clocks of release after each key; legal range 1..65535.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 key_code  input  4  key to press: [3:2] column index, [1:0] row index.
REQ-006 key_valid  input  1  key_code is offered this cycle.
REQ-007 key_ready  output  1  queue can accept key_code this cycle.
REQ-008 x  input  4  column drive from the keypad scanner, one-hot, active-high.
REQ-009 y  output  4  row sense returned to the scanner, active-high.
REQ-010 pressed  output  1  a key is currently closed.
REQ-011 busy  output  1  queue non-empty or state not IDLE.

Function
REQ-012 The block SHALL model a 4x4 switch matrix: the scanner drives columns on x and reads rows on y.
REQ-013 The block SHALL hold a 4-entry FIFO of key codes; key_ready = not full.
REQ-014 A push SHALL occur on any clock where key_valid and key_ready are both 1; key_valid with key_ready 0 SHALL be ignored, with no FIFO change.
REQ-015 A push and a pop in the same clock SHALL both take effect, so the count is unchanged; a push is allowed when full only if key_ready was 1, which it is not.
REQ-016 The FSM SHALL have states IDLE, PRESS and GAP, with a 16-bit down-counter cnt.
REQ-017 IDLE, FIFO non-empty: pop the head into cur_code, set cnt = PRESS_CYCLES-1, go to PRESS next clock.
REQ-018 IDLE, FIFO empty: remain in IDLE.
REQ-019 PRESS: decrement cnt; at cnt = 0, set cnt = GAP_CYCLES-1 and go to GAP.
REQ-020 PRESS SHALL last exactly PRESS_CYCLES clocks.
REQ-021 GAP: decrement cnt; at cnt = 0, go to IDLE.
REQ-022 GAP SHALL last exactly GAP_CYCLES clocks; the next key starts one IDLE clock later.
REQ-023 pressed SHALL be registered and equal 1 exactly while the state is PRESS.
REQ-024 y[r] SHALL be 1 iff pressed = 1, r = cur_code[1:0], and x[cur_code[3:2]] = 1; all other y bits SHALL be 0.
REQ-025 y SHALL be combinational from x (zero-cycle switch path), gated by registered state only.
REQ-026 When x is not one-hot, y SHALL follow the rule of REQ-024 using x[cur_code[3:2]] alone; other x bits SHALL have no effect.
REQ-027 key_code pushed while a key is in PRESS or GAP SHALL be queued and SHALL NOT alter cur_code.
REQ-028 The FIFO pointers SHALL wrap modulo 4; the occupancy counter is 3 bits, range 0..4.
REQ-029 busy SHALL be registered, = (state != IDLE) or (count != 0), reflecting post-edge state.

Reset
REQ-030 While rst = 1 at a clock edge: state = IDLE, cnt = 0, FIFO emptied, cur_code = 0.
REQ-031 While rst = 1 at a clock edge: pressed = 0, busy = 0; key_ready = 1 from the first clock after reset.
REQ-032 Reset asserted mid-PRESS SHALL drop y to all-zero in the same cycle pressed clears, with no GAP phase.
REQ-033 Pushes offered while rst = 1 SHALL be discarded.

Verification
REQ-034 PRESS_CYCLES=4, GAP_CYCLES=3: push 0x6 with x scanning 0001,0010,0100,1000 each clock -> pressed high 4 clocks; y = 0100 only while x = 0010; then 3 clocks of y = 0000.
REQ-035 Push 0x1,0x5,0x9,0xD back-to-back while in IDLE -> first popped the next clock; key_ready stays 1 because the pop frees a slot; all four keys replayed in order with exact PRESS/GAP timing.
REQ-036 Fill the FIFO with 4 codes during a long PRESS -> key_ready = 0; a 5th push is ignored; after the next pop key_ready = 1 and a push in that cycle is accepted.
REQ-037 x = 1111 during PRESS of 0xF -> y = 1000; x = 0111 -> y = 0000.
REQ-038 rst pulsed in mid-PRESS with 2 codes queued -> next clock pressed = 0, y = 0000, busy = 0, key_ready = 1; no queued keys are replayed.
REQ-039 PRESS_CYCLES=1, GAP_CYCLES=1 -> pressed high for exactly 1 clock; key-to-key period is 3 clocks.
